// File: rtl/vec_alu_seq_pkg.sv
// rtl/vec_alu_seq_pkg.sv - shared types, codes and config derivations for the vector ALU lane sequencer
package vec_alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } seq_state_t;

    localparam logic [2:0] OP_TYPE_VV = 3'b001;
    localparam logic [2:0] OP_TYPE_VX = 3'b010;
    localparam logic [2:0] OP_TYPE_VI = 3'b100;

    localparam logic [5:0] OPC_VADD = 6'b000000;
    localparam logic [5:0] OPC_VAND = 6'b001001;
    localparam logic [5:0] OPC_VOR  = 6'b001010;
    localparam logic [5:0] OPC_VXOR = 6'b001011;

    // Largest element width code the lane supports (SEW = 64).
    localparam logic [2:0] VSEW_MAX = 3'd3;

    // log2 of the element width in bits.
    function automatic logic [3:0] sew_log2(input logic [2:0] vsew);
        return {1'b0, vsew} + 4'd3;
    endfunction

    // Element width in bits; 11 bits so the widest illegal code still compares correctly.
    function automatic logic [10:0] sew_bits(input logic [2:0] vsew);
        return 11'd8 << vsew;
    endfunction

    // Elements held in one vector register.
    function automatic logic [9:0] elem_count(input logic [9:0] vlen, input logic [2:0] vsew);
        return vlen >> sew_log2(vsew);
    endfunction

    // Lane-width chunks needed to cover one element (at least one).
    function automatic logic [3:0] chunk_count(input logic [2:0] lane_width, input logic [2:0] vsew);
        if (sew_log2(vsew) <= {1'b0, lane_width}) begin
            return 4'd1;
        end
        return 4'd1 << (sew_log2(vsew) - {1'b0, lane_width});
    endfunction

endpackage

// File: rtl/vec_elem_counter.sv
// rtl/vec_elem_counter.sv - element/chunk stepping counter with hold, wrap and last-beat flag
module vec_elem_counter
    import vec_alu_seq_pkg::*;
#(
    parameter logic [2:0] LANE_WIDTH = 3'b100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       load,
    input  logic       advance,
    input  logic [9:0] start_elem,
    input  logic [3:0] elem_step,
    input  logic [9:0] elem_total,
    input  logic [3:0] chunk_last,
    input  logic [3:0] sew_log,
    output logic [9:0] elem,
    output logic [3:0] chunk,
    output logic       last,
    output logic [9:0] index
);

    // Final beat: no further owned element and this is the element's last chunk.
    assign last = (({1'b0, elem} + {7'b0, elem_step}) >= {1'b0, elem_total}) && (chunk == chunk_last);

    // Bit offset of the current chunk; shifts in 10-bit context wrap like the register address.
    assign index = (elem << sew_log) + ({6'b0, chunk} << LANE_WIDTH);

    // Step chunk first, then jump to the next owned element; hold on the final beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            elem  <= '0;
            chunk <= '0;
        end else if (clear) begin
            elem  <= '0;
            chunk <= '0;
        end else if (load) begin
            elem  <= start_elem;
            chunk <= '0;
        end else if (advance && !last) begin
            if (chunk == chunk_last) begin
                chunk <= '0;
                elem  <= elem + {6'b0, elem_step};
            end else begin
                chunk <= chunk + 4'd1;
            end
        end
    end

endmodule

// File: rtl/vec_alu_seq.sv
// rtl/vec_alu_seq.sv - per-lane sequencer stepping one ALU lane through its share of a vector op
module vec_alu_seq
    import vec_alu_seq_pkg::*;
#(
    parameter logic [9:0] VLEN       = 10'd128,
    parameter logic [2:0] LANE_WIDTH = 3'b100,
    parameter logic [2:0] LANE_I     = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_opcode,
    input  logic [2:0] cmd_op_type,
    input  logic [2:0] cmd_vsew,
    input  logic [1:0] cmd_nb_lanes,
    input  logic       stall,
    input  logic       kill,
    output logic       run,
    output logic [5:0] opcode,
    output logic [2:0] op_type,
    output logic [2:0] vsew,
    output logic [1:0] nb_lanes,
    output logic [9:0] index,
    output logic [3:0] in_reg_offset,
    output logic       wb_en,
    output logic       done,
    output logic       err
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       err_q;

    logic       cmd_fire;
    logic       cmd_illegal;
    logic       cmd_empty;
    logic [9:0] cmd_elems;
    logic [3:0] cmd_lanes;
    logic       busy_kill;

    logic [9:0] cnt_elem;
    logic [3:0] cnt_chunk;
    logic       cnt_last;
    logic [9:0] cnt_index;

    assign cmd_ready = (state_q == ST_IDLE);
    assign run       = (state_q == ST_RUN);
    assign wb_en     = run & ~stall;
    assign done      = (state_q == ST_FIN) & ~kill;
    assign err       = done & err_q;
    assign busy_kill = kill & (state_q != ST_IDLE);

    // The decision at the handshake uses the incoming fields; the latched copy is not visible yet.
    assign cmd_fire    = cmd_valid & cmd_ready;
    assign cmd_elems   = elem_count(VLEN, cmd_vsew);
    assign cmd_lanes   = 4'd1 << cmd_nb_lanes;
    assign cmd_illegal = (cmd_vsew > VSEW_MAX) || (sew_bits(cmd_vsew) > {1'b0, VLEN});
    assign cmd_empty   = ({1'b0, LANE_I} >= cmd_lanes) || ({7'b0, LANE_I} >= cmd_elems);

    vec_elem_counter #(
        .LANE_WIDTH(LANE_WIDTH)
    ) u_counter (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (busy_kill),
        .load      (cmd_fire & ~cmd_illegal & ~cmd_empty),
        .advance   (wb_en),
        .start_elem({7'b0, LANE_I}),
        .elem_step (4'd1 << nb_lanes),
        .elem_total(elem_count(VLEN, vsew)),
        .chunk_last(chunk_count(LANE_WIDTH, vsew) - 4'd1),
        .sew_log   (sew_log2(vsew)),
        .elem      (cnt_elem),
        .chunk     (cnt_chunk),
        .last      (cnt_last),
        .index     (cnt_index)
    );

    // Beat outputs are only meaningful while running; keep them quiet otherwise.
    assign index         = run ? cnt_index : '0;
    assign in_reg_offset = run ? cnt_chunk : '0;

    // Next-state: accept, step to the last beat, pulse completion; kill aborts any busy state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_illegal || cmd_empty) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall && cnt_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (busy_kill) begin
            state_d = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command fields stay latched until the next accepted command.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            opcode   <= '0;
            op_type  <= '0;
            vsew     <= '0;
            nb_lanes <= '0;
            err_q    <= 1'b0;
        end else if (cmd_fire) begin
            opcode   <= cmd_opcode;
            op_type  <= cmd_op_type;
            vsew     <= cmd_vsew;
            nb_lanes <= cmd_nb_lanes;
            err_q    <= cmd_illegal;
        end
    end

endmodule

// File: tb/tb_vec_alu_seq.sv
// tb/tb_vec_alu_seq.sv - self-checking bench for vec_alu_seq against a beat-list reference model
module tb_vec_alu_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [5:0] cmd_opcode;
    logic [2:0] cmd_op_type;
    logic [2:0] cmd_vsew;
    logic [1:0] cmd_nb_lanes;
    logic       stall;
    logic       kill;
    logic       run;
    logic [5:0] opcode;
    logic [2:0] op_type;
    logic [2:0] vsew;
    logic [1:0] nb_lanes;
    logic [9:0] index;
    logic [3:0] in_reg_offset;
    logic       wb_en;
    logic       done;
    logic       err;

    logic       cmd_ready1, run1, wb_en1, done1, err1;
    logic [5:0] opcode1;
    logic [2:0] op_type1, vsew1;
    logic [1:0] nb_lanes1;
    logic [9:0] index1;
    logic [3:0] in_reg_offset1;

    always #5 clk = ~clk;

    vec_alu_seq #(.VLEN(10'd128), .LANE_WIDTH(3'd4), .LANE_I(3'd0)) dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_op_type(cmd_op_type), .cmd_vsew(cmd_vsew),
        .cmd_nb_lanes(cmd_nb_lanes), .stall(stall), .kill(kill), .run(run),
        .opcode(opcode), .op_type(op_type), .vsew(vsew), .nb_lanes(nb_lanes),
        .index(index), .in_reg_offset(in_reg_offset), .wb_en(wb_en), .done(done), .err(err)
    );

    vec_alu_seq #(.VLEN(10'd128), .LANE_WIDTH(3'd4), .LANE_I(3'd1)) dut1 (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_opcode(cmd_opcode), .cmd_op_type(cmd_op_type), .cmd_vsew(cmd_vsew),
        .cmd_nb_lanes(cmd_nb_lanes), .stall(stall), .kill(kill), .run(run1),
        .opcode(opcode1), .op_type(op_type1), .vsew(vsew1), .nb_lanes(nb_lanes1),
        .index(index1), .in_reg_offset(in_reg_offset1), .wb_en(wb_en1), .done(done1), .err(err1)
    );

    typedef struct {
        int idx;
        int off;
    } beat_t;

    int checks = 0;
    int errors = 0;

    // Model: the remaining beats of the current op and a coarse phase (0 idle, 1 beats, 2 completion).
    beat_t q[$];
    int    mode = 0;
    int    m_err = 0;
    int    m_opc = 0, m_opt = 0, m_vs = 0, m_nl = 0;

    // Observations since the last handshake, for the hand-computed expectations.
    int    cyc = 0;
    int    seen_idx[$];
    int    seen_off[$];
    int    seen_wb[$];
    int    done_cyc = 0;
    int    done_err = 0;
    int    d1_done_cyc = 0;
    int    d1_err = 0;
    int    d1_runs = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Enumerate the owned beats of an op straight from the element/chunk rules.
    task automatic build(input int vs, input int nl, output int illegal);
        int sew, ne, nc, nlanes;
        q.delete();
        sew     = 8 << vs;
        ne      = 128 >> (vs + 3);
        nc      = (vs + 3 <= 4) ? 1 : (1 << (vs + 3 - 4));
        nlanes  = 1 << nl;
        illegal = (vs > 3 || sew > 128) ? 1 : 0;
        if (illegal == 0 && 0 < nlanes) begin
            for (int e = 0; e < ne; e += nlanes) begin
                for (int c = 0; c < nc; c++) begin
                    beat_t b;
                    b.idx = (e * sew + c * 16) % 1024;
                    b.off = c % 16;
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic check_outputs();
        int exp_done;
        cyc++;
        exp_done = (mode == 2 && !kill) ? 1 : 0;
        chk("cmd_ready", cmd_ready, mode == 0);
        chk("run", run, mode == 1);
        chk("done", done, exp_done);
        chk("err", err, exp_done & m_err);
        chk("wb_en", wb_en, (mode == 1 && !stall) ? 1 : 0);
        if (mode == 1) begin
            chk("index", index, q[0].idx);
            chk("in_reg_offset", in_reg_offset, q[0].off);
        end
        chk("opcode", opcode, m_opc);
        chk("op_type", op_type, m_opt);
        chk("vsew", vsew, m_vs);
        chk("nb_lanes", nb_lanes, m_nl);
        if (run) begin
            seen_idx.push_back(index);
            seen_off.push_back(in_reg_offset);
            seen_wb.push_back(wb_en);
        end
        if (done) begin
            done_cyc = cyc;
            done_err = err;
        end
        if (done1) begin
            d1_done_cyc = cyc;
            d1_err = err1;
        end
        if (run1) d1_runs++;
    endtask

    task automatic model_edge();
        int ill;
        if (kill && mode != 0) begin
            mode = 0;
            q.delete();
        end else if (mode == 0) begin
            if (cmd_valid) begin
                m_opc = cmd_opcode; m_opt = cmd_op_type; m_vs = cmd_vsew; m_nl = cmd_nb_lanes;
                build(cmd_vsew, cmd_nb_lanes, ill);
                cyc = 0; done_cyc = 0; done_err = 0; d1_done_cyc = 0; d1_err = 0; d1_runs = 0;
                seen_idx.delete(); seen_off.delete(); seen_wb.delete();
                if (ill != 0) begin
                    mode = 2; m_err = 1;
                end else if (q.size() == 0) begin
                    mode = 2; m_err = 0;
                end else begin
                    mode = 1; m_err = 0;
                end
            end
        end else if (mode == 1) begin
            if (!stall) begin
                void'(q.pop_front());
                if (q.size() == 0) mode = 2;
            end
        end else begin
            mode = 0;
        end
    endtask

    task automatic step(input logic v, input logic [2:0] vs, input logic [1:0] nl,
                        input logic st, input logic kl);
        @(posedge clk);
        #1;
        cmd_valid    = v;
        cmd_opcode   = 6'($urandom);
        cmd_op_type  = 3'($urandom);
        cmd_vsew     = vs;
        cmd_nb_lanes = nl;
        stall        = st;
        kill         = kl;
        @(negedge clk);
        check_outputs();
        model_edge();
    endtask

    task automatic run_op(input logic [2:0] vs, input logic [1:0] nl,
                          input logic [31:0] smask, input int kcyc);
        int k;
        step(1'b1, vs, nl, 1'b0, 1'b0);
        k = 1;
        while (mode != 0 && k < 200) begin
            step(1'b0, 3'($urandom), 2'($urandom), smask[k % 32], k == kcyc);
            k++;
        end
        if (mode != 0) chk("op_timeout", k, -1);
        step(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0; cmd_valid = 0; cmd_opcode = 0; cmd_op_type = 0;
        cmd_vsew = 0; cmd_nb_lanes = 0; stall = 0; kill = 0;
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_run", run, 0);
        chk("rst_done", done, 0);
        chk("rst_index", index, 0);
        @(negedge clk);
        resetn = 1'b1;

        // SEW=8, one lane: 16 beats stepping by 8 bits; lane 1 owns nothing and finishes at once.
        run_op(3'd0, 2'd0, 32'h0, -1);
        chk("c2_nbeats", seen_idx.size(), 16);
        if (seen_idx.size() == 16) chk("c2_last_index", seen_idx[15], 120);
        chk("c2_done_cyc", done_cyc, 17);
        chk("lane1_done_cyc", d1_done_cyc, 1);
        chk("lane1_err", d1_err, 0);
        chk("lane1_runs", d1_runs, 0);

        // SEW=32, two lanes: two chunks per element, every other element.
        run_op(3'd2, 2'd1, 32'h0, -1);
        begin
            int ei[4] = '{0, 16, 64, 80};
            int eo[4] = '{0, 1, 0, 1};
            chk("c1_nbeats", seen_idx.size(), 4);
            for (int i = 0; i < 4 && i < seen_idx.size(); i++) begin
                chk("c1_index", seen_idx[i], ei[i]);
                chk("c1_offset", seen_off[i], eo[i]);
            end
        end
        chk("c1_done_cyc", done_cyc, 5);
        chk("c1_done_err", done_err, 0);

        // SEW=64, one lane: four chunks per element.
        run_op(3'd3, 2'd0, 32'h0, -1);
        chk("c3_nbeats", seen_idx.size(), 8);
        for (int i = 0; i < 8 && i < seen_idx.size(); i++) begin
            chk("c3_index", seen_idx[i], 16 * i);
            chk("c3_offset", seen_off[i], i % 4);
        end
        chk("c3_done_cyc", done_cyc, 9);

        // Same op stalled during beats 2 and 3.
        run_op(3'd3, 2'd0, 32'h0000_000C, -1);
        chk("st_run_cycles", seen_idx.size(), 10);
        if (seen_idx.size() == 10) begin
            chk("st_hold_a", seen_idx[2], 16);
            chk("st_hold_b", seen_idx[3], 16);
            chk("st_wb_a", seen_wb[1], 0);
            chk("st_wb_b", seen_wb[2], 0);
            chk("st_wb_c", seen_wb[3], 1);
        end
        chk("st_done_cyc", done_cyc, 11);

        // Illegal element width.
        run_op(3'd4, 2'd0, 32'h0, -1);
        chk("il_done_cyc", done_cyc, 1);
        chk("il_err", done_err, 1);
        chk("il_nbeats", seen_idx.size(), 0);

        // Kill on beat 2 of the two-lane op.
        run_op(3'd2, 2'd1, 32'h0, 2);
        chk("kill_nbeats", seen_idx.size(), 2);
        chk("kill_no_done", done_cyc, 0);
        chk("kill_cmd_ready", cmd_ready, 1);

        // Asynchronous reset in the middle of a run.
        step(1'b1, 3'd2, 2'd1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        cmd_valid = 0; stall = 0; kill = 0;
        #1;
        chk("arst_run", run, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_index", index, 0);
        chk("arst_done", done, 0);
        chk("arst_opcode", opcode, 0);
        chk("arst_vsew", vsew, 0);
        mode = 0; q.delete(); m_err = 0; m_opc = 0; m_opt = 0; m_vs = 0; m_nl = 0;
        @(negedge clk);
        resetn = 1'b1;

        // Randomised traffic, including commands offered while busy.
        for (int n = 0; n < 1500; n++) begin
            logic [2:0] vs;
            vs = ($urandom_range(0, 99) < 85) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            step($urandom_range(0, 99) < 30, vs, 2'($urandom),
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
Per-lane sequencer for the vector ALU lane datapath. It accepts one vector-op command via a valid/ready handshake and latches its configuration. It then steps the lane through every element and chunk it owns, driving run, index and in_reg_offset once per cycle, and pulses done when the lane's share of the vector is finished. It sits between the vector decode stage and one ALU lane instance, with one sequencer per lane.

Parameters:
VLEN, 10'd128, vector register length in bits.
LANE_WIDTH, 3'b100, log2 of lane width in bits (lane processes LW = 1<<LANE_WIDTH bits per beat).
LANE_I, 3'b000, index of the lane this sequencer drives.

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command offered.
cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
cmd_opcode  in  6  ALU opcode.
cmd_op_type  in  3  001 VV, 010 VX, 100 VI.
cmd_vsew  in  3  element width code; SEW = 8<<vsew.
cmd_nb_lanes  in  2  active lanes L = 1<<nb_lanes.
stall  in  1  hold the current beat (destination write port busy).
kill  in  1  abort the current op.
run  out  1  ALU lane evaluates this beat.
opcode  out  6  latched opcode to ALU.
op_type  out  3  latched op_type to ALU.
vsew  out  3  latched vsew to ALU.
nb_lanes  out  2  latched nb_lanes to ALU.
index  out  10  bit offset of current chunk in vs2/vd.
in_reg_offset  out  4  chunk number within current element.
wb_en  out  1  result of this beat is to be written (run & !stall).
done  out  1  one-cycle completion pulse.
err  out  1  qualifies done: illegal configuration.

Behaviour:
- Reset: every output is 0 except cmd_ready, which is 1. State is IDLE and all latched fields are 0. Asserting resetn low mid-op clears everything immediately, with no done.
- Derived values, from the latched config:
  - E = VLEN>>(vsew+3), the element count.
  - C = (vsew+3 <= LANE_WIDTH) ? 1 : 1<<(vsew+3-LANE_WIDTH), the chunks per element.
  - Owned elements: e = LANE_I, LANE_I+L, LANE_I+2L, … while e < E.
- Per-beat outputs: index = e*SEW + in_reg_offset*LW, truncated to 10 bits. in_reg_offset counts 0..C-1, then wraps to 0 as e advances by L.
- States: IDLE, RUN, FIN.
  - IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) latches all cmd_* fields.
    - If vsew>3 or SEW>VLEN: go to FIN with err=1.
    - Else if LANE_I >= L or LANE_I >= E: go to FIN with err=0, zero beats.
    - Else: go to RUN with e=LANE_I and in_reg_offset=0.
  - RUN: run=1.
    - stall=1: index, in_reg_offset and e hold; wb_en=0.
    - Otherwise the counters advance at the clock edge.
    - On the last beat (e+L >= E and in_reg_offset == C-1, not stalled), go to FIN.
  - FIN: done=1 for exactly one cycle, err as determined above, run=0, then go to IDLE. cmd_ready stays 0 during FIN.
- Latency: the first beat is the cycle after the handshake. Beat count N = ceil((E-LANE_I)/L)*C plus the stall cycles. done is asserted in cycle N+1 after the handshake.
- kill has priority over stall and advance. Any state except IDLE goes to IDLE next cycle with run=0 and no done. kill in IDLE is ignored.
- Latched opcode, op_type, vsew and nb_lanes hold stable from the handshake until the next accepted command. They are not cleared at FIN.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared include vec_defs.vh holds:
  - VV/VX/VI op_type codes.
  - Opcode constants: VADD 000000, VAND 001001, VOR 001010, VXOR 001011.
  - State encodings IDLE/RUN/FIN.
  - The C and E derivation as macros.
- One natural sub-module: vec_elem_counter (element/chunk counter with hold, wrap and last-beat flag). The FSM stays in vec_alu_seq.

Test Plan:
- VLEN=128, LANE_WIDTH=4, LANE_I=0; vsew=2, nb_lanes=1 -> 4 beats: index 0,16,64,80; in_reg_offset 0,1,0,1; done=1, err=0 in cycle 5.
- vsew=0, nb_lanes=0 -> 16 beats, index 0,8,…,120, in_reg_offset always 0; done in cycle 17.
- vsew=3, nb_lanes=0 -> index 0,16,32,48,64,80,96,112; in_reg_offset 0,1,2,3,0,1,2,3; done in cycle 9.
- Previous case with stall high on beats 2–3 -> index 16 held for 3 cycles with wb_en=0 while stalled; done delayed to cycle 11.
- vsew=4 -> no run, done=1 and err=1 in cycle 1. Separately, LANE_I=1 with nb_lanes=0 -> done=1, err=0 in cycle 1 with no beats.
- kill asserted on beat 2 of the first case -> run=0 the next cycle, no done, cmd_ready=1. resetn low mid-RUN -> all outputs 0 asynchronously, cmd_ready=1.
